// File: rtl/spram_arb_pkg.sv
// Shared types for the SPRAM arbiter: access owner encoding and arbitration policy codes.
package spram_arb_pkg;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    localparam int PRIO_RR = 0;
    localparam int PRIO_B  = 1;

endpackage

// File: rtl/spram_arb_rr.sv
// Two-way winner pick (round-robin or B-priority) plus the A starvation counter.
// Bit 0 of req_i/gnt_o is port A, bit 1 is port B.
module spram_arb_rr
    import spram_arb_pkg::*;
#(
    parameter int MAXWAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       locked_i,
    input  logic       policy_i,
    output logic [1:0] gnt_o,
    output logic [3:0] wait_cnt_o
);

    localparam logic [3:0] WAIT_MAX = 4'(MAXWAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        gnt_o = 2'b00;
        if (locked_i) begin
            gnt_o[1] = req_i[1];
        end else if (req_i == 2'b11) begin
            if (policy_i) begin
                // B normally wins; A gets one access once it has lost MAXWAIT times in a row.
                gnt_o = (wait_cnt_q == WAIT_MAX) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = (last_i == OWN_A) ? 2'b10 : 2'b01;
            end
        end else begin
            gnt_o = req_i;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req_i[0] || gnt_o[0]) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_cnt_o = wait_cnt_q;

endmodule

// File: rtl/spram_arb.sv
// Arbiter/sequencer sharing one single-port SRAM between an instruction-fetch port (A)
// and a data port (B); tracks the one-cycle read latency and steers read data to its owner.
module spram_arb
    import spram_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 15,
    parameter int PRIO    = 0,
    parameter int MAXWAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_req,
    input  logic [AW-1:0]   a_ai,
    output logic            a_gnt,
    output logic            a_rdy,
    output logic [DW-1:0]   a_vo,
    input  logic            b_req,
    input  logic            b_we,
    input  logic [AW-1:0]   b_ai,
    input  logic [DW-1:0]   b_vi,
    input  logic [DW/8-1:0] b_bmsk,
    input  logic            b_lock,
    output logic            b_gnt,
    output logic            b_rdy,
    output logic [DW-1:0]   b_vo,
    output logic [AW-1:0]   m_ai,
    output logic [DW-1:0]   m_vi,
    output logic            m_we,
    output logic [DW/8-1:0] m_bmsk,
    input  logic [DW-1:0]   m_vo
);

    owner_e        last_q, last_d;
    owner_e        pend_own_q, pend_own_d;
    logic          locked_q, locked_d;
    logic          pend_v_q, pend_v_d;
    logic [AW-1:0] m_ai_q, m_ai_d;
    logic [1:0]    req, gnt;
    logic [3:0]    wait_cnt;
    logic          policy;

    // Requests are masked during reset so no access reaches the RAM while rst is high.
    assign req    = {b_req, a_req} & {2{~rst}};
    assign policy = (PRIO == PRIO_B);

    spram_arb_rr #(
        .MAXWAIT(MAXWAIT)
    ) u_pick (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .last_i    (last_q),
        .locked_i  (locked_q & b_lock),
        .policy_i  (policy),
        .gnt_o     (gnt),
        .wait_cnt_o(wait_cnt)
    );

    assign a_gnt = gnt[0];
    assign b_gnt = gnt[1];

    always_comb begin
        m_ai_d     = m_ai_q;
        m_vi       = '0;
        m_we       = 1'b0;
        m_bmsk     = '0;
        last_d     = last_q;
        pend_v_d   = 1'b0;
        pend_own_d = pend_own_q;
        locked_d   = locked_q;
        if (gnt[0]) begin
            m_ai_d     = a_ai;
            m_bmsk     = '1;
            last_d     = OWN_A;
            pend_v_d   = 1'b1;
            pend_own_d = OWN_A;
        end else if (gnt[1]) begin
            m_ai_d = b_ai;
            m_vi   = b_vi;
            m_we   = b_we;
            m_bmsk = b_bmsk;
            last_d = OWN_B;
            if (!b_we) begin
                pend_v_d   = 1'b1;
                pend_own_d = OWN_B;
            end
        end
        // The first cycle with b_lock low releases ownership and is arbitrated normally.
        if (gnt[1] && b_lock) begin
            locked_d = 1'b1;
        end else if (!b_lock) begin
            locked_d = 1'b0;
        end
    end

    // An idle bus keeps the last address to avoid needless toggling.
    assign m_ai = m_ai_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= OWN_A;
            pend_own_q <= OWN_A;
            locked_q   <= 1'b0;
            pend_v_q   <= 1'b0;
            m_ai_q     <= '0;
        end else begin
            last_q     <= last_d;
            pend_own_q <= pend_own_d;
            locked_q   <= locked_d;
            pend_v_q   <= pend_v_d;
            m_ai_q     <= m_ai_d;
        end
    end

    assign a_rdy = pend_v_q && (pend_own_q == OWN_A);
    assign b_rdy = pend_v_q && (pend_own_q == OWN_B);
    assign a_vo  = a_rdy ? m_vo : '0;
    assign b_vo  = b_rdy ? m_vo : '0;

endmodule

// File: tb/tb_spram_arb.sv
// Bench for spram_arb: a round-robin instance (dut) and a B-priority instance (dut_p),
// each with its own behavioural SRAM, driven by shared request inputs.
module tb_spram_arb;

    logic        clk, rst;
    logic        a_req, b_req, b_we, b_lock;
    logic [14:0] a_ai, b_ai;
    logic [31:0] b_vi;
    logic [3:0]  b_bmsk;

    logic        a_gnt, a_rdy, b_gnt, b_rdy, m_we;
    logic [31:0] a_vo, b_vo, m_vi, m_vo;
    logic [14:0] m_ai;
    logic [3:0]  m_bmsk;

    logic        p_a_gnt, p_a_rdy, p_b_gnt, p_b_rdy, p_m_we;
    logic [31:0] p_a_vo, p_b_vo, p_m_vi, p_m_vo;
    logic [14:0] p_m_ai;
    logic [3:0]  p_m_bmsk;

    logic [31:0] ram   [0:32767];
    logic [31:0] p_ram [0:32767];
    logic [31:0] ref_mem [0:32767];
    logic [32:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    bit last_m;
    bit locked_m;

    spram_arb #(.DW(32), .AW(15), .PRIO(0), .MAXWAIT(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_ai(a_ai), .a_gnt(a_gnt), .a_rdy(a_rdy), .a_vo(a_vo),
        .b_req(b_req), .b_we(b_we), .b_ai(b_ai), .b_vi(b_vi), .b_bmsk(b_bmsk), .b_lock(b_lock),
        .b_gnt(b_gnt), .b_rdy(b_rdy), .b_vo(b_vo),
        .m_ai(m_ai), .m_vi(m_vi), .m_we(m_we), .m_bmsk(m_bmsk), .m_vo(m_vo)
    );

    spram_arb #(.DW(32), .AW(15), .PRIO(1), .MAXWAIT(4)) dut_p (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_ai(a_ai), .a_gnt(p_a_gnt), .a_rdy(p_a_rdy), .a_vo(p_a_vo),
        .b_req(b_req), .b_we(b_we), .b_ai(b_ai), .b_vi(b_vi), .b_bmsk(b_bmsk), .b_lock(b_lock),
        .b_gnt(p_b_gnt), .b_rdy(p_b_rdy), .b_vo(p_b_vo),
        .m_ai(p_m_ai), .m_vi(p_m_vi), .m_we(p_m_we), .m_bmsk(p_m_bmsk), .m_vo(p_m_vo)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SPRAMs: byte-masked write, registered read, output holds on write/idle.
    always @(posedge clk) begin
        if (m_we) begin
            for (int i = 0; i < 4; i++) if (m_bmsk[i]) ram[m_ai][8*i +: 8] <= m_vi[8*i +: 8];
        end else if (|m_bmsk) begin
            m_vo <= ram[m_ai];
        end
    end

    always @(posedge clk) begin
        if (p_m_we) begin
            for (int i = 0; i < 4; i++) if (p_m_bmsk[i]) p_ram[p_m_ai][8*i +: 8] <= p_m_vi[8*i +: 8];
        end else if (|p_m_bmsk) begin
            p_m_vo <= p_ram[p_m_ai];
        end
    end

    function automatic logic [31:0] pat(input logic [14:0] addr);
        return 32'hAAAA0000 | {17'd0, addr};
    endfunction

    // Reference winner from the arbitration rules: 0 none, 1 A, 2 B (round-robin policy).
    function automatic int pick(input bit a, input bit b, input bit lk);
        if (locked_m && lk) return b ? 2 : 0;
        if (a && b) return last_m ? 1 : 2;
        if (a) return 1;
        if (b) return 2;
        return 0;
    endfunction

    task automatic idle_inputs;
        a_req = 0; a_ai = '0; b_req = 0; b_we = 0; b_ai = '0; b_vi = '0; b_bmsk = '0; b_lock = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        a_req = 1; b_req = 1; b_bmsk = 4'hF;
        @(negedge clk); #1;
        n_checks++;
        if ({a_gnt, b_gnt, a_rdy, b_rdy, m_we, m_bmsk} !== 9'd0) begin
            n_errors++; $display("FAIL reset_ctl: got %b want 0", {a_gnt, b_gnt, a_rdy, b_rdy, m_we, m_bmsk});
        end
        n_checks++;
        if ({a_vo, b_vo, p_a_gnt, p_b_gnt, p_m_we} !== 67'd0) begin
            n_errors++; $display("FAIL reset_vo: a_vo=%h b_vo=%h p_gnt=%b%b want 0", a_vo, b_vo, p_a_gnt, p_b_gnt);
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_a;
        @(negedge clk); a_req = 1; a_ai = 15'h10; #1;
        n_checks++;
        if ({a_gnt, b_gnt, m_ai, m_we, m_bmsk} !== {2'b10, 15'h10, 1'b0, 4'hF}) begin
            n_errors++; $display("FAIL single_g0: gnt=%b%b m_ai=%h we=%b msk=%h", a_gnt, b_gnt, m_ai, m_we, m_bmsk);
        end
        @(negedge clk); a_ai = 15'h11; #1;
        n_checks++;
        if ({a_gnt, a_rdy, b_rdy, a_vo, b_vo} !== {3'b110, 32'hAAAA0010, 32'd0}) begin
            n_errors++; $display("FAIL single_r0: gnt=%b rdy=%b%b a_vo=%h want AAAA0010", a_gnt, a_rdy, b_rdy, a_vo);
        end
        @(negedge clk); a_req = 0; #1;
        n_checks++;
        if ({a_gnt, a_rdy, b_rdy, a_vo, m_ai, m_bmsk} !== {3'b010, 32'hAAAA0011, 15'h11, 4'h0}) begin
            n_errors++; $display("FAIL single_r1: gnt=%b rdy=%b%b a_vo=%h m_ai=%h msk=%h", a_gnt, a_rdy, b_rdy, a_vo, m_ai, m_bmsk);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({a_rdy, b_rdy} !== 2'b00) begin
            n_errors++; $display("FAIL single_end: rdy=%b%b want 00", a_rdy, b_rdy);
        end
    endtask

    task automatic test_alternate;
        logic [14:0] aa, ba;
        logic [31:0] pd;
        bit pb, pv;
        aa = 15'h40; ba = 15'h60; pv = 0; pb = 0; pd = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_req = 1; a_ai = aa; b_req = 1; b_we = 0; b_ai = ba; b_bmsk = 4'hF; b_lock = 0;
            #1;
            n_checks++;
            if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_errors++; $display("FAIL alt_gnt%0d: gnt=%b%b", i, a_gnt, b_gnt);
            end
            if (pv) begin
                n_checks++;
                if ({a_rdy, b_rdy, a_vo, b_vo} !== (pb ? {2'b01, 32'd0, pd} : {2'b10, pd, 32'd0})) begin
                    n_errors++; $display("FAIL alt_rdy%0d: rdy=%b%b a_vo=%h b_vo=%h want %h", i, a_rdy, b_rdy, a_vo, b_vo, pd);
                end
            end
            pv = 1; pb = (i % 2 == 0);
            if (pb) begin pd = pat(ba); ba++; end
            else begin pd = pat(aa); aa++; end
        end
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if ({a_rdy, b_rdy, a_vo} !== {2'b10, pd}) begin
            n_errors++; $display("FAIL alt_last: rdy=%b%b a_vo=%h want %h", a_rdy, b_rdy, a_vo, pd);
        end
    endtask

    task automatic test_lock;
        @(negedge clk);
        a_req = 1; a_ai = 15'h50; b_req = 1; b_we = 0; b_ai = 15'h20; b_bmsk = 4'hF; b_lock = 1;
        #1;
        n_checks++;
        if ({a_gnt, b_gnt} !== 2'b01) begin
            n_errors++; $display("FAIL lock_c1: gnt=%b%b want 01", a_gnt, b_gnt);
        end
        @(negedge clk); b_we = 1; b_bmsk = 4'b0001; b_vi = 32'hFF; #1;
        n_checks++;
        if ({a_gnt, b_gnt, m_we, m_bmsk, b_rdy, b_vo} !== {3'b011, 4'b0001, 1'b1, 32'h12345678}) begin
            n_errors++; $display("FAIL lock_c2: gnt=%b%b we=%b msk=%b b_rdy=%b b_vo=%h", a_gnt, b_gnt, m_we, m_bmsk, b_rdy, b_vo);
        end
        @(negedge clk); b_req = 0; #1;
        n_checks++;
        if ({a_gnt, b_gnt, m_we, m_bmsk, m_ai, b_rdy} !== {3'b000, 4'h0, 15'h20, 1'b0}) begin
            n_errors++; $display("FAIL lock_idle: gnt=%b%b we=%b msk=%h m_ai=%h b_rdy=%b", a_gnt, b_gnt, m_we, m_bmsk, m_ai, b_rdy);
        end
        @(negedge clk); b_lock = 0; #1;
        n_checks++;
        if ({a_gnt, b_gnt, a_rdy, b_rdy} !== 4'b1000) begin
            n_errors++; $display("FAIL lock_rel: gnt=%b%b rdy=%b%b want 1000", a_gnt, b_gnt, a_rdy, b_rdy);
        end
        @(negedge clk); a_req = 0; b_req = 1; b_we = 0; b_bmsk = 4'hF; #1;
        n_checks++;
        if ({b_gnt, a_rdy, a_vo} !== {2'b11, 32'hAAAA0050}) begin
            n_errors++; $display("FAIL lock_rb: b_gnt=%b a_rdy=%b a_vo=%h want AAAA0050", b_gnt, a_rdy, a_vo);
        end
        @(negedge clk); b_req = 0; #1;
        n_checks++;
        if ({a_rdy, b_rdy, b_vo} !== {2'b01, 32'h123456FF}) begin
            n_errors++; $display("FAIL lock_data: rdy=%b%b b_vo=%h want 123456FF", a_rdy, b_rdy, b_vo);
        end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        b_req = 1; b_we = 1; b_ai = 15'h30; b_vi = 32'hDEADBEEF; b_bmsk = 4'hF; b_lock = 0;
        #1;
        n_checks++;
        if ({b_gnt, m_we, m_vi, m_ai} !== {2'b11, 32'hDEADBEEF, 15'h30}) begin
            n_errors++; $display("FAIL wr_issue: gnt=%b we=%b m_vi=%h m_ai=%h", b_gnt, m_we, m_vi, m_ai);
        end
        @(negedge clk); b_we = 0; #1;
        n_checks++;
        if ({b_gnt, m_we, b_rdy} !== 3'b100) begin
            n_errors++; $display("FAIL wr_rd: gnt=%b we=%b b_rdy=%b want 100", b_gnt, m_we, b_rdy);
        end
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if ({b_rdy, b_vo} !== {1'b1, 32'hDEADBEEF}) begin
            n_errors++; $display("FAIL wr_data: b_rdy=%b b_vo=%h want DEADBEEF", b_rdy, b_vo);
        end
    endtask

    task automatic test_random;
        bit a_p, b_p, ear, ebr;
        logic [31:0] eav, ebv;
        logic [32:0] e;
        int w;
        a_p = 0; b_p = 0;
        last_m = 1; locked_m = 0;
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!a_p && c < 300 && $urandom_range(0, 1) == 1) begin
                a_p = 1; a_ai = 15'($urandom_range(64, 511));
            end
            if (!b_p && c < 300 && $urandom_range(0, 1) == 1) begin
                b_p = 1;
                b_we = 1'($urandom_range(0, 1));
                b_ai = b_we ? 15'($urandom_range(256, 511)) : 15'($urandom_range(64, 511));
                b_vi = $urandom;
                b_bmsk = b_we ? 4'($urandom_range(1, 15)) : 4'hF;
            end
            b_lock = (c < 300) && ($urandom_range(0, 3) == 0);
            a_req = a_p; b_req = b_p;
            #1;
            ear = 0; ebr = 0; eav = '0; ebv = '0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e[32]) begin ebr = 1; ebv = e[31:0]; end
                else begin ear = 1; eav = e[31:0]; end
            end
            n_checks++;
            if ({a_rdy, b_rdy, a_vo, b_vo} !== {ear, ebr, eav, ebv}) begin
                n_errors++; $display("FAIL rnd_rdy c%0d: rdy=%b%b a_vo=%h b_vo=%h want %b%b %h %h", c, a_rdy, b_rdy, a_vo, b_vo, ear, ebr, eav, ebv);
            end
            w = pick(a_p, b_p, b_lock);
            n_checks++;
            if ({a_gnt, b_gnt} !== {w == 1, w == 2}) begin
                n_errors++; $display("FAIL rnd_gnt c%0d: gnt=%b%b want winner %0d", c, a_gnt, b_gnt, w);
            end
            if (w == 1) begin
                n_checks++;
                if ({m_ai, m_we, m_bmsk} !== {a_ai, 1'b0, 4'hF}) begin
                    n_errors++; $display("FAIL rnd_bus_a c%0d: m_ai=%h we=%b msk=%h", c, m_ai, m_we, m_bmsk);
                end
                exp_q.push_back({1'b0, ref_mem[a_ai]});
                a_p = 0;
            end else if (w == 2) begin
                n_checks++;
                if ({m_ai, m_we, m_bmsk, m_vi} !== {b_ai, b_we, b_bmsk, b_vi}) begin
                    n_errors++; $display("FAIL rnd_bus_b c%0d: m_ai=%h we=%b msk=%h vi=%h", c, m_ai, m_we, m_bmsk, m_vi);
                end
                if (b_we) begin
                    for (int i = 0; i < 4; i++) if (b_bmsk[i]) ref_mem[b_ai][8*i +: 8] = b_vi[8*i +: 8];
                end else begin
                    exp_q.push_back({1'b1, ref_mem[b_ai]});
                end
                b_p = 0;
            end else begin
                n_checks++;
                if ({m_we, m_bmsk} !== 5'd0) begin
                    n_errors++; $display("FAIL rnd_idle c%0d: we=%b msk=%h", c, m_we, m_bmsk);
                end
            end
            if (w != 0) last_m = (w == 2);
            if (w == 2 && b_lock) locked_m = 1;
            else if (!b_lock) locked_m = 0;
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_reset_mid;
        @(negedge clk); a_req = 1; a_ai = 15'h12; #1;
        n_checks++;
        if (a_gnt !== 1'b1) begin
            n_errors++; $display("FAIL rmid_gnt: a_gnt=%b want 1", a_gnt);
        end
        @(posedge clk); #1;
        rst = 1; a_req = 0;
        #1;
        n_checks++;
        if ({a_rdy, a_vo, m_we} !== 34'd0) begin
            n_errors++; $display("FAIL rmid_rst: a_rdy=%b a_vo=%h we=%b want 0", a_rdy, a_vo, m_we);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) rst = 0;
            #1;
            n_checks++;
            if ({a_rdy, b_rdy, a_gnt, m_we} !== 4'd0) begin
                n_errors++; $display("FAIL rmid_hold%0d: rdy=%b%b gnt=%b we=%b want 0", i, a_rdy, b_rdy, a_gnt, m_we);
            end
        end
    endtask

    task automatic test_after_reset;
        @(negedge clk);
        a_req = 1; a_ai = 15'h61; b_req = 1; b_we = 0; b_ai = 15'h62; b_bmsk = 4'hF; b_lock = 0;
        #1;
        n_checks++;
        if ({a_gnt, b_gnt} !== 2'b01) begin
            n_errors++; $display("FAIL post_first: gnt=%b%b want 01", a_gnt, b_gnt);
        end
        @(negedge clk); b_req = 0; #1;
        n_checks++;
        if ({a_gnt, b_rdy, b_vo} !== {2'b11, 32'hAAAA0062}) begin
            n_errors++; $display("FAIL post_second: a_gnt=%b b_rdy=%b b_vo=%h", a_gnt, b_rdy, b_vo);
        end
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if ({a_rdy, a_vo} !== {1'b1, 32'hAAAA0061}) begin
            n_errors++; $display("FAIL post_data: a_rdy=%b a_vo=%h want AAAA0061", a_rdy, a_vo);
        end
    endtask

    task automatic test_prio_b;
        logic [14:0] aa, ba;
        logic [31:0] pd;
        bit pb, pv, a_win;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        aa = 15'h80; ba = 15'hC0; pv = 0; pb = 0; pd = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            a_req = 1; a_ai = aa; b_req = 1; b_we = 0; b_ai = ba; b_bmsk = 4'hF; b_lock = 0;
            #1;
            a_win = (i % 5 == 4);
            n_checks++;
            if ({p_a_gnt, p_b_gnt} !== {a_win, !a_win}) begin
                n_errors++; $display("FAIL prio_gnt%0d: gnt=%b%b want %b%b", i, p_a_gnt, p_b_gnt, a_win, !a_win);
            end
            if (pv) begin
                n_checks++;
                if ({p_a_rdy, p_b_rdy, p_a_vo, p_b_vo} !== (pb ? {2'b01, 32'd0, pd} : {2'b10, pd, 32'd0})) begin
                    n_errors++; $display("FAIL prio_rdy%0d: rdy=%b%b a_vo=%h b_vo=%h want %h", i, p_a_rdy, p_b_rdy, p_a_vo, p_b_vo, pd);
                end
            end
            pv = 1; pb = !a_win;
            if (pb) begin pd = pat(ba); ba++; end
            else begin pd = pat(aa); aa++; end
        end
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if ({p_a_rdy, p_b_rdy, p_a_vo} !== {2'b10, pd}) begin
            n_errors++; $display("FAIL prio_last: rdy=%b%b a_vo=%h want %h", p_a_rdy, p_b_rdy, p_a_vo, pd);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i] = pat(15'(i));
            p_ram[i] = pat(15'(i));
            ref_mem[i] = pat(15'(i));
        end
        ram[15'h20] = 32'h12345678;
        p_ram[15'h20] = 32'h12345678;
        test_reset();
        test_single_a();
        test_alternate();
        test_lock();
        test_write_read();
        test_random();
        test_reset_mid();
        test_after_reset();
        test_prio_b();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
